// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel between NREQ requesters, with message locking.
// Optional grant revocation on requester stall is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        tx_d_o,
    output logic              tx_d_valid_o,
    input  logic              tx_ready_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [7:0]      tx_d_reg, tx_d_next;
    logic            tx_v_reg, tx_v_next;

    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic [IW:0]     sum;
    logic [IW-1:0]   owner_inc;
    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_data;
    logic            accept;

    // Rotating priority search: iterate from the farthest offset down so the
    // nearest requester at or after the pointer wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (req_valid_i[sum[IW-1:0]]) begin
                hit     = 1'b1;
                hit_idx = sum[IW-1:0];
            end
        end
    end

    assign owner_inc   = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
    assign owner_valid = req_valid_i[owner_reg];
    assign owner_last  = req_last_i[owner_reg];
    assign owner_data  = req_data_i[{owner_reg, 3'b000} +: 8];

    // A byte is taken when the output register is empty or draining this cycle.
    assign accept      = (state_reg == ARB_LOCK) && owner_valid && (!tx_v_reg || tx_ready_i);
    assign req_ready_o = accept ? grant_reg : '0;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] stall_reg, stall_next;
    logic [15:0] stall_inc;
    logic        timeout_reg, timeout_next;
    logic        revoke;

    assign stall_inc = stall_reg + 16'd1;
    assign revoke    = (state_reg == ARB_LOCK) && !owner_valid && (stall_inc == 16'(TIMEOUT_CYCLES));

    always_comb begin
        stall_next   = '0;
        timeout_next = revoke;
        if (state_reg == ARB_LOCK && !accept && !owner_valid && !revoke) begin
            stall_next = stall_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            stall_reg   <= stall_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    logic revoke;

    assign revoke    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        grant_next = grant_reg;
        tx_d_next  = tx_d_reg;
        tx_v_next  = tx_v_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (hit) begin
                    state_next = ARB_LOCK;
                    owner_next = hit_idx;
                    grant_next = NREQ'(1) << hit_idx;
                end
            end
            ARB_LOCK: begin
                if ((accept && owner_last) || revoke) begin
                    state_next = ARB_IDLE;
                    ptr_next   = owner_inc;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase

        // Output register drains independently of the arbitration state.
        if (accept) begin
            tx_d_next = owner_data;
            tx_v_next = 1'b1;
        end else if (tx_ready_i) begin
            tx_v_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            grant_reg <= '0;
            tx_d_reg  <= '0;
            tx_v_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            grant_reg <= grant_next;
            tx_d_reg  <= tx_d_next;
            tx_v_reg  <= tx_v_next;
        end
    end

    assign tx_d_o       = tx_d_reg;
    assign tx_d_valid_o = tx_v_reg;
    assign grant_o      = grant_reg;
    assign busy_o       = (state_reg == ARB_LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected TX bytes and grants are queued by the
// stimulus and popped by an independent monitor on each TX handshake / new grant.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  tx_d;
    logic        tx_d_valid;
    logic        tx_ready;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .tx_d_o       (tx_d),
        .tx_d_valid_o (tx_d_valid),
        .tx_ready_i   (tx_ready),
        .grant_o      (grant),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] rmem [3][32];
    int head [3] = '{0, 0, 0};
    int tail [3] = '{0, 0, 0};
    logic [2:0] hs = '0;

    logic [7:0] exp_tx [$];
    logic [2:0] exp_gnt [$];
    int beat_cyc [64];
    int nbeat = 0;
    logic [2:0] prev_grant = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rpush(input int r, input logic [7:0] b, input logic last);
        rmem[r][tail[r]] = {last, b};
        tail[r]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_gnt.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain_left"}, exp_tx.size() + exp_gnt.size(), 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Requester model: presents the head of each queue, advances on a handshake.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (hs[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*8 +: 8]   = rmem[i][head[i]][7:0];
                    req_last[i]          = rmem[i][head[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every TX handshake and every new grant against the queues.
    initial begin
        logic [7:0] eb;
        logic [2:0] eg;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready & {3{rst_n}};
            if (tx_d_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", tx_d, 'h100);
                end else begin
                    eb = exp_tx.pop_front();
                    check("tx_byte", tx_d, eb);
                end
                if (nbeat < 64) beat_cyc[nbeat] = cyc;
                nbeat++;
            end
            if (grant != 3'b000 && prev_grant == 3'b000) begin
                if (exp_gnt.size() == 0) begin
                    check("grant_unexpected", grant, 0);
                end else begin
                    eg = exp_gnt.pop_front();
                    check("grant_order", grant, eg);
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        int b0;
        int n;
        int t0;
        bit saw_to;
        rst_n    = 1'b0;
        tx_ready = 1'b1;

        // Reset with requesters valid, then message integrity
        rpush(0, 8'h41, 1'b0);
        rpush(0, 8'h42, 1'b0);
        rpush(0, 8'h43, 1'b1);
        rpush(1, 8'h55, 1'b1);
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_txvalid", tx_d_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        exp_gnt.push_back(3'b001);
        exp_gnt.push_back(3'b010);
        exp_tx.push_back(8'h41);
        exp_tx.push_back(8'h42);
        exp_tx.push_back(8'h43);
        exp_tx.push_back(8'h55);
        b0 = nbeat;
        rst_n = 1'b1;
        wait_drain("msg", 40);
        check("msg_gap01", beat_cyc[b0+1] - beat_cyc[b0], 1);
        check("msg_gap12", beat_cyc[b0+2] - beat_cyc[b0+1], 1);
        check("msg_gap23", beat_cyc[b0+3] - beat_cyc[b0+2], 2);

        // Round-robin with single-byte messages from every requester
        rst_n = 1'b0;
        tick();
        rpush(0, 8'h10, 1'b1);
        rpush(0, 8'h11, 1'b1);
        rpush(1, 8'h20, 1'b1);
        rpush(1, 8'h21, 1'b1);
        rpush(2, 8'h30, 1'b1);
        rpush(2, 8'h31, 1'b1);
        for (int k = 0; k < 6; k++) exp_gnt.push_back(3'b001 << (k % 3));
        exp_tx.push_back(8'h10);
        exp_tx.push_back(8'h20);
        exp_tx.push_back(8'h30);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h31);
        b0 = nbeat;
        rst_n = 1'b1;
        wait_drain("rr", 60);
        for (int k = 1; k < 6; k++) check("rr_spacing", beat_cyc[b0+k] - beat_cyc[b0+k-1], 2);

        // Backpressure: 0x7E held while the TX side stalls
        tick();
        tx_ready = 1'b0;
        rpush(0, 8'h7E, 1'b0);
        rpush(0, 8'h7F, 1'b1);
        exp_gnt.push_back(3'b001);
        exp_tx.push_back(8'h7E);
        exp_tx.push_back(8'h7F);
        n = 0;
        while (!tx_d_valid && n < 10) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_data", tx_d, 8'h7E);
            check("bp_valid", tx_d_valid, 1);
            check("bp_ready", req_ready, 0);
            tick();
        end
        tx_ready = 1'b1;
        wait_drain("bp", 30);

        // Reset after the second of four bytes
        rpush(1, 8'h61, 1'b0);
        rpush(1, 8'h62, 1'b0);
        rpush(1, 8'h63, 1'b0);
        rpush(1, 8'h64, 1'b1);
        rpush(0, 8'h99, 1'b1);
        rpush(2, 8'h98, 1'b1);
        exp_gnt.push_back(3'b010);
        exp_tx.push_back(8'h61);
        exp_tx.push_back(8'h62);
        n = 0;
        while (!(tx_d_valid && tx_d == 8'h62) && n < 20) begin
            tick();
            n++;
        end
        check("mr_reached_byte2", tx_d, 8'h62);
        rst_n = 1'b0;
        head[1] = tail[1];
        tick();
        check("mr_grant", grant, 0);
        check("mr_ready", req_ready, 0);
        check("mr_txvalid", tx_d_valid, 0);
        check("mr_busy", busy, 0);
        exp_gnt.push_back(3'b001);
        exp_gnt.push_back(3'b100);
        exp_tx.push_back(8'h99);
        exp_tx.push_back(8'h98);
        rst_n = 1'b1;
        wait_drain("mr", 40);

        // Owner stalls mid-message while requester 2 waits
        rpush(1, 8'h71, 1'b0);
        rpush(2, 8'h72, 1'b1);
        exp_gnt.push_back(3'b010);
        exp_tx.push_back(8'h71);
        b0 = nbeat;
        wait_drain("stall_first", 20);
        t0 = beat_cyc[b0];
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 30) begin
            tick();
            n++;
        end
        check("to_pulse", timeout, 1);
        check("to_delay", cyc - t0, 8);
        check("to_grant", grant, 0);
        tick();
        check("to_pulse_width", timeout, 0);
        exp_gnt.push_back(3'b100);
        exp_tx.push_back(8'h72);
        wait_drain("to", 30);
`else
        saw_to = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (timeout) saw_to = 1'b1;
        end
        check("hold_cycles", (cyc - t0) >= 20, 1);
        check("hold_timeout", saw_to, 0);
        check("hold_grant", grant, 3'b010);
        check("hold_busy", busy, 1);
        check("hold_ready", req_ready, 0);
        rpush(1, 8'h73, 1'b1);
        exp_tx.push_back(8'h73);
        exp_tx.push_back(8'h72);
        exp_gnt.push_back(3'b100);
        wait_drain("hold", 30);
`endif
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
